// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC generator: FSM states, next-PC sources and
// the bundle-size helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        TRAP     = 3'd0,
        REDIRECT = 3'd1,
        PRED     = 3'd2,
        SEQ      = 3'd3,
        HOLD     = 3'd4
    } pc_src_t;

    // Bytes covered by one fetch bundle of 32-bit instructions.
    function automatic int fetch_bytes(input int fetch_width);
        return 4 * fetch_width;
    endfunction

endpackage

// File: rtl/fetch_mask_gen.sv
// Per-slot valid mask for a bundle: slot i is valid when it sits at or above
// the word offset of the fetch PC within its aligned bundle.
module fetch_mask_gen #(
    parameter int FETCH_WIDTH = 2,
    parameter int OFF_W       = 1
) (
    input  logic [OFF_W-1:0]       offset,
    output logic [FETCH_WIDTH-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask[i] = (i >= int'(offset));
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: boot/run/halt control, prioritised next-PC selection and
// slot mask. Define FETCH_PC_PERF_EN to build the saturating perf counters.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              FETCH_WIDTH  = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trap_en,
    input  logic [XLEN-1:0]        trap_target,
    input  logic                   redirect_en,
    input  logic [XLEN-1:0]        redirect_target,
    input  logic                   pred_en,
    input  logic [XLEN-1:0]        pred_target,
    input  logic                   halt_req,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [XLEN-1:0]        fetch_pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   flush,
    output logic [31:0]            perf_redirects,
    output logic [31:0]            perf_stall_cycles
);

    localparam int              FETCH_BYTES = fetch_bytes(FETCH_WIDTH);
    localparam int              LOG2_FB     = $clog2(FETCH_BYTES);
    localparam int              OFF_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK  = {XLEN{1'b1}} << LOG2_FB;
    localparam logic [XLEN-1:0] WORD_MASK   = {XLEN{1'b1}} << 2;

    fetch_state_t            state_q;
    fetch_state_t            state_d;
    pc_src_t                 src;
    logic [XLEN-1:0]         pc_d;
    logic [FETCH_WIDTH-1:0]  mask_d;
    logic [OFF_W-1:0]        mask_off;
    logic                    handshake;
    logic                    redirect_taken;

    assign handshake      = fetch_valid && fetch_ready;
    assign redirect_taken = trap_en || redirect_en;

    always_comb begin
        src = HOLD;
        if (trap_en)                    src = TRAP;
        else if (redirect_en)           src = REDIRECT;
        else if (handshake && pred_en)  src = PRED;
        else if (handshake)             src = SEQ;
    end

    always_comb begin
        pc_d = fetch_pc;
        unique case (src)
            TRAP:     pc_d = trap_target & WORD_MASK;
            REDIRECT: pc_d = redirect_target & WORD_MASK;
            PRED:     pc_d = pred_target & WORD_MASK;
            SEQ:      pc_d = (fetch_pc & ALIGN_MASK) + XLEN'(FETCH_BYTES);
            default:  pc_d = fetch_pc;
        endcase
    end

    // Halting waits until the offered bundle has been consumed, so no bundle is lost.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req && (!fetch_valid || handshake)) state_d = HALTED;
            HALTED:  if (!halt_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (redirect_taken) state_d = RUN;
    end

    generate
        if (FETCH_WIDTH > 1) begin : g_off
            assign mask_off = pc_d[LOG2_FB-1:2];
        end else begin : g_off_single
            assign mask_off = 1'b0;
        end
    endgenerate

    fetch_mask_gen #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .OFF_W       (OFF_W)
    ) u_mask_gen (
        .offset (mask_off),
        .mask   (mask_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BOOT;
            fetch_valid <= 1'b0;
            fetch_pc    <= RESET_VECTOR;
            fetch_mask  <= '1;
            flush       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_valid <= (state_d == RUN);
            fetch_pc    <= pc_d;
            fetch_mask  <= mask_d;
            flush       <= redirect_taken;
        end
    end

`ifdef FETCH_PC_PERF_EN
    logic [31:0] redirects_q;
    logic [31:0] stalls_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirects_q <= '0;
            stalls_q    <= '0;
        end else begin
            if (redirect_taken)              redirects_q <= sat_inc(redirects_q);
            if (fetch_valid && !fetch_ready) stalls_q    <= sat_inc(stalls_q);
        end
    end

    assign perf_redirects    = redirects_q;
    assign perf_stall_cycles = stalls_q;
`else
    assign perf_redirects    = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a cycle-level reference model and
// hand-computed checkpoints (FETCH_WIDTH=2, RESET_VECTOR=0).
module tb_fetch_pc_gen;

    localparam int FW = 2;
    localparam int FB = 4 * FW;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trap_en, redirect_en, pred_en, halt_req, fetch_ready;
    logic [31:0] trap_target, redirect_target, pred_target;
    logic        fetch_valid, flush;
    logic [31:0] fetch_pc, perf_redirects, perf_stall_cycles;
    logic [FW-1:0] fetch_mask;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_pc_gen #(
        .XLEN         (32),
        .FETCH_WIDTH  (FW),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .trap_en           (trap_en),
        .trap_target       (trap_target),
        .redirect_en       (redirect_en),
        .redirect_target   (redirect_target),
        .pred_en           (pred_en),
        .pred_target       (pred_target),
        .halt_req          (halt_req),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_pc          (fetch_pc),
        .fetch_mask        (fetch_mask),
        .flush             (flush),
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] perf_exp(input longint v);
`ifdef FETCH_PC_PERF_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return (v < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    // Reference model: tracks what the fetch stream must look like cycle by cycle.
    logic [31:0] m_pc;
    logic [FW-1:0] m_mask;
    bit          m_valid, m_flush, m_boot, m_halted;
    longint      m_redir, m_stall;

    function automatic logic [FW-1:0] lane_mask(input logic [31:0] pc);
        int off;
        off = int'(pc % FB) / 4;
        return FW'(((1 << FW) - 1) & ~((1 << off) - 1));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = 32'h0; m_valid = 0; m_flush = 0; m_boot = 1; m_halted = 0;
            m_redir = 0; m_stall = 0;
        end else begin
            bit hs;
            hs = m_valid && fetch_ready;
            if (m_valid && !fetch_ready) m_stall++;
            m_flush = 0;
            if (trap_en || redirect_en) begin
                m_pc = (trap_en ? trap_target : redirect_target) & ~32'h3;
                m_flush = 1; m_redir++; m_boot = 0; m_halted = 0; m_valid = 1;
            end else if (m_boot) begin
                m_boot = 0; m_valid = 1;
            end else if (m_halted) begin
                if (!halt_req) begin m_halted = 0; m_valid = 1; end
            end else begin
                if (hs) m_pc = pred_en ? (pred_target & ~32'h3) : (m_pc - (m_pc % FB) + FB);
                if (halt_req && hs) begin m_halted = 1; m_valid = 0; end
            end
        end
        m_mask = lane_mask(m_pc);
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("model_valid", 64'(fetch_valid), 64'(m_valid));
            check("model_pc",    64'(fetch_pc),    64'(m_pc));
            check("model_mask",  64'(fetch_mask),  64'(m_mask));
            check("model_flush", 64'(flush),       64'(m_flush));
            check("model_perf_redir", 64'(perf_redirects),    64'(perf_exp(m_redir)));
            check("model_perf_stall", 64'(perf_stall_cycles), 64'(perf_exp(m_stall)));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] pc,
                              input logic [FW-1:0] mask, input logic fl);
        check({name, "_valid"}, 64'(fetch_valid), 64'(v));
        check({name, "_pc"},    64'(fetch_pc),    64'(pc));
        check({name, "_mask"},  64'(fetch_mask),  64'(mask));
        check({name, "_flush"}, 64'(flush),       64'(fl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 0; trap_en = 0; redirect_en = 0; pred_en = 0; halt_req = 0;
        fetch_ready = 1; trap_target = 0; redirect_target = 0; pred_target = 0;
        cyc(2);
        expect_out("reset", 1'b0, 32'h0, 2'b11, 1'b0);
        check("reset_perf_redir", 64'(perf_redirects), 64'h0);
        check("reset_perf_stall", 64'(perf_stall_cycles), 64'h0);

        // Boot then sequential stream
        reset_n = 1;
        #1 check("boot_valid", 64'(fetch_valid), 64'h0);
        cyc(); expect_out("seq0", 1'b1, 32'h0,  2'b11, 1'b0);
        cyc(); expect_out("seq1", 1'b1, 32'h8,  2'b11, 1'b0);
        cyc(); expect_out("seq2", 1'b1, 32'h10, 2'b11, 1'b0);

        // Three-cycle stall
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_out("stall", 1'b1, 32'h10, 2'b11, 1'b0);
        end
        check("stall_count", 64'(perf_stall_cycles), 64'(perf_exp(3)));
        fetch_ready = 1;
        cyc(); expect_out("after_stall", 1'b1, 32'h18, 2'b11, 1'b0);

        // Unaligned redirect while stalled
        fetch_ready = 0; redirect_en = 1; redirect_target = 32'h106;
        cyc(); expect_out("redir", 1'b1, 32'h104, 2'b10, 1'b1);
        check("redir_count", 64'(perf_redirects), 64'(perf_exp(1)));
        redirect_en = 0; fetch_ready = 1;
        cyc(); expect_out("redir_next", 1'b1, 32'h108, 2'b11, 1'b0);

        // Priority: trap over redirect over prediction
        trap_en = 1; trap_target = 32'h200; redirect_en = 1; redirect_target = 32'h300;
        pred_en = 1; pred_target = 32'h500;
        cyc(); expect_out("prio", 1'b1, 32'h200, 2'b11, 1'b1);
        trap_en = 0; redirect_en = 0; pred_en = 0;

        // Address wrap
        redirect_en = 1; redirect_target = 32'hFFFF_FFF8;
        cyc(); expect_out("wrap_pre", 1'b1, 32'hFFFF_FFF8, 2'b11, 1'b1);
        redirect_en = 0;
        cyc(); expect_out("wrap", 1'b1, 32'h0, 2'b11, 1'b0);

        // Prediction taken on handshake, ignored without one
        pred_en = 1; pred_target = 32'h84;
        cyc(); expect_out("pred", 1'b1, 32'h84, 2'b10, 1'b0);
        fetch_ready = 0; pred_target = 32'h90;
        cyc(); expect_out("pred_nohs", 1'b1, 32'h84, 2'b10, 1'b0);
        pred_en = 0; fetch_ready = 1;
        cyc(); expect_out("pred_seq", 1'b1, 32'h88, 2'b11, 1'b0);

        // Halt after accepting bundle at 0x40
        redirect_en = 1; redirect_target = 32'h40;
        cyc(); redirect_en = 0; halt_req = 1;
        cyc(); expect_out("halt", 1'b0, 32'h48, 2'b11, 1'b0);
        cyc(); expect_out("halt_hold", 1'b0, 32'h48, 2'b11, 1'b0);
        halt_req = 0;
        cyc(); expect_out("resume", 1'b1, 32'h48, 2'b11, 1'b0);

        // Halt requested during a stall waits for the handshake
        halt_req = 1; fetch_ready = 0;
        cyc(); expect_out("halt_stall", 1'b1, 32'h48, 2'b11, 1'b0);
        fetch_ready = 1;
        cyc(); expect_out("halt_late", 1'b0, 32'h50, 2'b11, 1'b0);

        // Redirect wakes a halted fetcher
        redirect_en = 1; redirect_target = 32'h204;
        cyc(); expect_out("halt_redir", 1'b1, 32'h204, 2'b10, 1'b1);
        redirect_en = 0; halt_req = 0;
        cyc(); expect_out("halt_redir_next", 1'b1, 32'h208, 2'b11, 1'b0);

        // Asynchronous reset in the middle of a stall with a redirect pending
        fetch_ready = 0; redirect_en = 1; redirect_target = 32'h700;
        #3 reset_n = 0;
        #1 expect_out("async_rst", 1'b0, 32'h0, 2'b11, 1'b0);
        check("async_rst_perf", 64'(perf_redirects), 64'h0);
        redirect_en = 0; fetch_ready = 1;
        cyc(); reset_n = 1;
        cyc(); expect_out("rst_boot", 1'b1, 32'h0, 2'b11, 1'b0);
        cyc(); expect_out("rst_seq", 1'b1, 32'h8, 2'b11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
